fft_mag_peak: RTL

FFT_MAG_PEAK -- requirements
Module: fft_mag_peak

---
 rtl/fft_mag_peak.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/fft_mag_peak.sv
// ============================================================================
// Module   : fft_mag_peak
// Purpose  : |X|^2 of an FFT output stream, with per-frame peak bin tracking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_mag_peak #(
    parameter int N_FFT = 128,
    parameter int IW    = 24,
    parameter int IDXW  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2*IW-1:0]   s_tdata,
    input  logic [IDXW-1:0]   s_tuser,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic              s_tlast,
    output logic [2*IW-1:0]   m_tdata,
    output logic [IDXW-1:0]   m_tuser,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              peak_valid,
    output logic [IDXW-1:0]   peak_idx,
    output logic [2*IW-1:0]   peak_mag,
    output logic              frame_err,
    output logic              idx_err
);

    localparam int MW = 2 * IW;
    localparam logic [IDXW-1:0] c_last_bin = IDXW'(N_FFT - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } state_t;

    state_t r_state, w_state_nxt;
    logic [IDXW-1:0] r_cnt, w_cnt_nxt;

    logic                   r_s1_valid, r_s1_last, r_s1_first, r_s1_err;
    logic signed [IW-1:0]   r_s1_i, r_s1_q;
    logic [IDXW-1:0]        r_s1_idx;

    logic                   r_m_tvalid, r_m_tlast;
    logic [MW-1:0]          r_m_tdata;
    logic [IDXW-1:0]        r_m_tuser;

    logic [MW-1:0]          r_run_mag, r_peak_mag;
    logic [IDXW-1:0]        r_run_idx, r_peak_idx;
    logic                   r_peak_valid, r_frame_err, r_idx_err;

    logic w_advance, w_accept, w_at_end, w_close;
    logic signed [MW-1:0]   w_i_ext, w_q_ext;
    logic [MW-1:0]          w_ii, w_qq, w_mag;
    logic                   w_take;
    logic [MW-1:0]          w_best_mag;
    logic [IDXW-1:0]        w_best_idx;

    assign w_advance = m_tready || !r_m_tvalid;
    assign s_tready  = w_advance;
    assign w_accept  = s_tvalid && w_advance;
    assign w_at_end  = (r_cnt == c_last_bin);
    assign w_close   = w_accept && (s_tlast || w_at_end);

    // Sign-extend before squaring so the product is formed at full width;
    // each square is non-negative and at most 2^(MW-2), so the sum fits MW bits.
    assign w_i_ext = {{IW{r_s1_i[IW-1]}}, r_s1_i};
    assign w_q_ext = {{IW{r_s1_q[IW-1]}}, r_s1_q};
    assign w_ii    = $unsigned(w_i_ext * w_i_ext);
    assign w_qq    = $unsigned(w_q_ext * w_q_ext);
    assign w_mag   = w_ii + w_qq;

    assign w_take     = r_s1_first || (w_mag > r_run_mag);
    assign w_best_mag = w_take ? w_mag    : r_run_mag;
    assign w_best_idx = w_take ? r_s1_idx : r_run_idx;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_accept) begin
            if (w_close) begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end else begin
                w_state_nxt = ST_FRAME;
                w_cnt_nxt   = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_s1_valid   <= 1'b0;
            r_s1_last    <= 1'b0;
            r_s1_first   <= 1'b0;
            r_s1_err     <= 1'b0;
            r_s1_i       <= '0;
            r_s1_q       <= '0;
            r_s1_idx     <= '0;
            r_m_tvalid   <= 1'b0;
            r_m_tlast    <= 1'b0;
            r_m_tdata    <= '0;
            r_m_tuser    <= '0;
            r_run_mag    <= '0;
            r_run_idx    <= '0;
            r_peak_mag   <= '0;
            r_peak_idx   <= '0;
            r_peak_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_idx_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_peak_valid <= 1'b0;
            r_frame_err  <= 1'b0;

            if (w_accept && (s_tuser != r_cnt)) begin
                r_idx_err <= 1'b1;
            end

            if (w_advance) begin
                r_s1_valid <= s_tvalid;
                if (s_tvalid) begin
                    r_s1_i     <= s_tdata[IW-1:0];
                    r_s1_q     <= s_tdata[2*IW-1:IW];
                    r_s1_idx   <= r_cnt;
                    r_s1_last  <= w_close;
                    r_s1_first <= (r_state == ST_IDLE);
                    // Malformed: tlast early, or the last bin arrived without tlast.
                    r_s1_err   <= (s_tlast != w_at_end);
                end

                r_m_tvalid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_m_tdata <= w_mag;
                    r_m_tuser <= r_s1_idx;
                    r_m_tlast <= r_s1_last;
                    r_run_mag <= w_best_mag;
                    r_run_idx <= w_best_idx;
                    if (r_s1_last) begin
                        r_peak_mag   <= w_best_mag;
                        r_peak_idx   <= w_best_idx;
                        r_peak_valid <= 1'b1;
                        r_frame_err  <= r_s1_err;
                    end
                end
            end
        end
    end

    assign m_tdata    = r_m_tdata;
    assign m_tuser    = r_m_tuser;
    assign m_tvalid   = r_m_tvalid;
    assign m_tlast    = r_m_tlast;
    assign peak_valid = r_peak_valid;
    assign peak_idx   = r_peak_idx;
    assign peak_mag   = r_peak_mag;
    assign frame_err  = r_frame_err;
    assign idx_err    = r_idx_err;

endmodule

`default_nettype wire
